ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 14 +
 rtl/ram_arbiter_rr.sv | 22 ++
 rtl/ram_arbiter.sv | 155 +++++++++++++++
 tb/tb_ram_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and widths for the two-port RAM arbiter.
package ram_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    // Arbiter FSM state encoding, kept as plain constants for legacy tools
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ACCESS  = 2'd1;
    localparam state_t ST_RECOVER = 2'd2;

endpackage

// File: rtl/ram_arbiter_rr.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to
// whichever requester was not granted last.
module ram_arbiter_rr (
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // One-hot grant from the current requests and the previous winner
    always_comb begin
        o_grant = 2'b00;
        if (i_req0 && i_req1) begin
            o_grant = i_last_grant ? 2'b01 : 2'b10;
        end else if (i_req0) begin
            o_grant = 2'b01;
        end else if (i_req1) begin
            o_grant = 2'b10;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one asynchronous 64Kx8 RAM between two requesters. Each access runs
// IDLE -> ACCESS (WAIT+1 cycles) -> RECOVER (1 cycle) with all RAM-side and
// requester-side outputs driven straight from flops.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_wr0,
    input  logic              i_wr1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_data0,
    input  logic [DATA_W-1:0] i_data1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_data0,
    output logic [DATA_W-1:0] o_data1,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_enable_x,
    output logic              o_ram_write_x,
    output logic [DATA_W-1:0] o_ram_data,
    input  logic [DATA_W-1:0] i_ram_data
);

    localparam logic [2:0] WAIT_CNT = 3'(WAIT);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              cur_q, cur_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              ram_enable_x_q, ram_enable_x_d;
    logic              ram_write_x_q, ram_write_x_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] data0_q, data0_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic [1:0]        grant;

    ram_arbiter_rr u_rr (
        .i_req0       (i_req0),
        .i_req1       (i_req1),
        .i_last_grant (last_grant_q),
        .o_grant      (grant)
    );

    // Next-state logic: grant and latch in IDLE, count down in ACCESS, ack on exit
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_grant_d   = last_grant_q;
        cur_d          = cur_q;
        wr_d           = wr_q;
        ram_addr_d     = ram_addr_q;
        ram_data_d     = ram_data_q;
        ram_enable_x_d = ram_enable_x_q;
        ram_write_x_d  = ram_write_x_q;
        ack0_d         = 1'b0;
        ack1_d         = 1'b0;
        data0_d        = data0_q;
        data1_d        = data1_q;

        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    state_d        = ST_ACCESS;
                    cnt_d          = WAIT_CNT;
                    cur_d          = grant[1];
                    last_grant_d   = grant[1];
                    wr_d           = grant[1] ? i_wr1 : i_wr0;
                    ram_addr_d     = grant[1] ? i_addr1 : i_addr0;
                    ram_data_d     = grant[1] ? i_data1 : i_data0;
                    ram_enable_x_d = 1'b0;
                    ram_write_x_d  = grant[1] ? !i_wr1 : !i_wr0;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 3'd0) begin
                    state_d        = ST_RECOVER;
                    ram_enable_x_d = 1'b1;
                    ram_write_x_d  = 1'b1;
                    if (cur_q) begin
                        ack1_d = 1'b1;
                        if (!wr_q) begin
                            data1_d = i_ram_data;
                        end
                    end else begin
                        ack0_d = 1'b1;
                        if (!wr_q) begin
                            data0_d = i_ram_data;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset back to an idle, disabled RAM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 3'd0;
            last_grant_q   <= 1'b1;
            cur_q          <= 1'b0;
            wr_q           <= 1'b0;
            ram_addr_q     <= '0;
            ram_data_q     <= '0;
            ram_enable_x_q <= 1'b1;
            ram_write_x_q  <= 1'b1;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            data0_q        <= '0;
            data1_q        <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_grant_q   <= last_grant_d;
            cur_q          <= cur_d;
            wr_q           <= wr_d;
            ram_addr_q     <= ram_addr_d;
            ram_data_q     <= ram_data_d;
            ram_enable_x_q <= ram_enable_x_d;
            ram_write_x_q  <= ram_write_x_d;
            ack0_q         <= ack0_d;
            ack1_q         <= ack1_d;
            data0_q        <= data0_d;
            data1_q        <= data1_d;
        end
    end

    assign o_ack0         = ack0_q;
    assign o_ack1         = ack1_q;
    assign o_data0        = data0_q;
    assign o_data1        = data1_q;
    assign o_ram_addr     = ram_addr_q;
    assign o_ram_enable_x = ram_enable_x_q;
    assign o_ram_write_x  = ram_write_x_q;
    assign o_ram_data     = ram_data_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (WAIT=0 and WAIT=3) each with its own
// RAM model, checked against a transaction-level reference of the arbiter.
module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        sel;
    logic [1:0]  reqV;
    logic [1:0]  wrV;
    logic [15:0] addrV [2];
    logic [7:0]  dataV [2];

    logic        a_req0, a_req1, b_req0, b_req1;
    logic        a_ack0, a_ack1, b_ack0, b_ack1;
    logic [7:0]  a_data0, a_data1, b_data0, b_data1;
    logic [15:0] a_ram_addr, b_ram_addr;
    logic        a_en_x, a_wr_x, b_en_x, b_wr_x;
    logic [7:0]  a_wdata, b_wdata, a_rdata, b_rdata;

    logic [7:0]  ramA [0:65535];
    bit          ramAValid [0:65535];
    logic [7:0]  ramB [0:65535];
    bit          ramBValid [0:65535];

    logic        oAck0, oAck1, oEnX, oWrX;
    logic [7:0]  oData0, oData1, oWData;
    logic [15:0] oAddr;

    // reference model state
    int          k, nextSample, expAckAt, curWait;
    bit          busy, g, gWr, lastGrant;
    logic [15:0] gAddr;
    logic [7:0]  gData;
    logic [7:0]  expData [2];
    logic [7:0]  refMem [0:65535];

    // observation bookkeeping
    bit          prevEnX, ack1Seen;
    int          grantObsK, ackObsK, lowCnt;
    logic [15:0] obsAddrQ[$];
    int          obsKQ[$];

    int          nAsserts, nFail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign a_req0 = reqV[0] & ~sel;
    assign a_req1 = reqV[1] & ~sel;
    assign b_req0 = reqV[0] & sel;
    assign b_req1 = reqV[1] & sel;

    ram_arbiter #(.WAIT(0)) dut_a (
        .clk(clk), .rst(rst),
        .i_req0(a_req0), .i_req1(a_req1), .i_wr0(wrV[0]), .i_wr1(wrV[1]),
        .i_addr0(addrV[0]), .i_addr1(addrV[1]), .i_data0(dataV[0]), .i_data1(dataV[1]),
        .o_ack0(a_ack0), .o_ack1(a_ack1), .o_data0(a_data0), .o_data1(a_data1),
        .o_ram_addr(a_ram_addr), .o_ram_enable_x(a_en_x), .o_ram_write_x(a_wr_x),
        .o_ram_data(a_wdata), .i_ram_data(a_rdata)
    );

    ram_arbiter #(.WAIT(3)) dut_b (
        .clk(clk), .rst(rst),
        .i_req0(b_req0), .i_req1(b_req1), .i_wr0(wrV[0]), .i_wr1(wrV[1]),
        .i_addr0(addrV[0]), .i_addr1(addrV[1]), .i_data0(dataV[0]), .i_data1(dataV[1]),
        .o_ack0(b_ack0), .o_ack1(b_ack1), .o_data0(b_data0), .o_data1(b_data1),
        .o_ram_addr(b_ram_addr), .o_ram_enable_x(b_en_x), .o_ram_write_x(b_wr_x),
        .o_ram_data(b_wdata), .i_ram_data(b_rdata)
    );

    // RAM A: unwritten locations read a fixed address pattern, writes commit on write_x rising
    always @(posedge a_wr_x) begin
        if (!rst) begin
            ramA[a_ram_addr]      <= a_wdata;
            ramAValid[a_ram_addr] <= 1'b1;
        end
    end
    assign a_rdata = !a_en_x ? (ramAValid[a_ram_addr] ? ramA[a_ram_addr] : 8'(a_ram_addr * 7 + 3)) : 8'h00;

    // RAM B: preloaded with $C3 everywhere
    always @(posedge b_wr_x) begin
        if (!rst) begin
            ramB[b_ram_addr]      <= b_wdata;
            ramBValid[b_ram_addr] <= 1'b1;
        end
    end
    assign b_rdata = !b_en_x ? (ramBValid[b_ram_addr] ? ramB[b_ram_addr] : 8'hC3) : 8'h00;

    assign oAck0  = sel ? b_ack0 : a_ack0;
    assign oAck1  = sel ? b_ack1 : a_ack1;
    assign oData0 = sel ? b_data0 : a_data0;
    assign oData1 = sel ? b_data1 : a_data1;
    assign oAddr  = sel ? b_ram_addr : a_ram_addr;
    assign oEnX   = sel ? b_en_x : a_en_x;
    assign oWrX   = sel ? b_wr_x : a_wr_x;
    assign oWData = sel ? b_wdata : a_wdata;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference: grant rule, access window, ack and data outcome
    task automatic modelStep();
        bit enLow, expAck0, expAck1;
        if (rst) begin
            busy       = 1'b0;
            lastGrant  = 1'b1;
            nextSample = k + 1;
            gAddr      = 16'h0000;
            gData      = 8'h00;
            gWr        = 1'b0;
            expData[0] = 8'h00;
            expData[1] = 8'h00;
        end else if (!busy && k == nextSample) begin
            if (reqV != 2'b00) begin
                if (reqV == 2'b11) g = ~lastGrant;
                else               g = reqV[1];
                lastGrant  = g;
                busy       = 1'b1;
                gWr        = wrV[g];
                gAddr      = addrV[g];
                gData      = dataV[g];
                expAckAt   = k + curWait + 1;
                nextSample = k + curWait + 3;
            end else begin
                nextSample = k + 1;
            end
        end
        enLow   = busy && (k < expAckAt);
        expAck0 = busy && (k == expAckAt) && !g;
        expAck1 = busy && (k == expAckAt) && g;
        checkOutput("ram_enable_x", oEnX, !enLow);
        checkOutput("ram_write_x", oWrX, !(enLow && gWr));
        checkOutput("ram_addr", oAddr, gAddr);
        checkOutput("ram_data", oWData, gData);
        if (busy && k == expAckAt) begin
            if (gWr) refMem[gAddr] = gData;
            else     expData[g] = refMem[gAddr];
            busy = 1'b0;
        end
        checkOutput("ack0", oAck0, expAck0);
        checkOutput("ack1", oAck1, expAck1);
        checkOutput("ack_exclusive", oAck0 & oAck1, 0);
        checkOutput("data0", oData0, expData[0]);
        checkOutput("data1", oData1, expData[1]);
        if (oEnX == 1'b0 && prevEnX == 1'b1) begin
            grantObsK = k;
            obsAddrQ.push_back(oAddr);
            obsKQ.push_back(k);
        end
        prevEnX = oEnX;
        if (oEnX == 1'b0) lowCnt++;
        if (oAck0) ackObsK = k;
        if (oAck1) begin
            ackObsK  = k;
            ack1Seen = 1'b1;
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        k++;
        @(negedge clk);
        modelStep();
    endtask

    task automatic doReset();
        rst  = 1'b1;
        reqV = 2'b00;
        applyStimulus();
        applyStimulus();
        rst  = 1'b0;
    endtask

    task automatic doTxn(input int n, input bit wr, input logic [15:0] addr, input logic [7:0] data);
        bit ok;
        reqV[n]  = 1'b1;
        wrV[n]   = wr;
        addrV[n] = addr;
        dataV[n] = data;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            applyStimulus();
            if ((n == 0 ? oAck0 : oAck1) === 1'b1) ok = 1'b1;
        end
        checkOutput("txn_ack_seen", ok, 1);
        reqV[n] = 1'b0;
    endtask

    task automatic randomDrive();
        for (int n = 0; n < 2; n++) begin
            if (reqV[n] && (n == 0 ? oAck0 : oAck1)) begin
                reqV[n] = 1'b0;
            end else if (reqV[n] && busy && g == n[0]) begin
                addrV[n] = 16'($urandom);
                dataV[n] = 8'($urandom);
                wrV[n]   = ~wrV[n];
            end else if (reqV[n] && $urandom_range(19) == 0) begin
                reqV[n] = 1'b0;
            end
            if (!reqV[n] && $urandom_range(2) == 0) begin
                reqV[n]  = 1'b1;
                wrV[n]   = 1'($urandom_range(1));
                addrV[n] = {12'h0AB, 4'($urandom_range(15))};
                dataV[n] = 8'($urandom);
            end
        end
    endtask

    initial begin
        logic [15:0] tieAddr [2];
        logic [15:0] a;
        bit          done;

        nAsserts = 0;
        nFail    = 0;
        k        = 0;
        sel      = 1'b0;
        curWait  = 0;
        prevEnX  = 1'b1;
        lowCnt   = 0;
        ack1Seen = 1'b0;
        busy     = 1'b0;
        rst      = 1'b1;
        reqV     = 2'b00;
        wrV      = 2'b00;
        addrV[0] = 16'h0000; addrV[1] = 16'h0000;
        dataV[0] = 8'h00;    dataV[1] = 8'h00;
        for (int i = 0; i < 65536; i++) refMem[i] = 8'(i * 7 + 3);

        $display("[TB] reset and reset-value checks");
        doReset();

        $display("[TB] single write then read on requester 0");
        ack1Seen = 1'b0;
        doTxn(0, 1'b1, 16'h1234, 8'h5A);
        checkOutput("wr_latency", ackObsK - grantObsK, 1);
        doTxn(0, 1'b0, 16'h1234, 8'h00);
        checkOutput("rd_latency", ackObsK - grantObsK, 1);
        checkOutput("rd_data0_5a", oData0, 8'h5A);
        checkOutput("ack1_never", ack1Seen, 0);

        $display("[TB] held tie alternates");
        doReset();
        tieAddr[0] = 16'h0010;
        tieAddr[1] = 16'h0020;
        obsAddrQ.delete();
        obsKQ.delete();
        reqV = 2'b11; wrV = 2'b00;
        addrV[0] = tieAddr[0]; addrV[1] = tieAddr[1];
        for (int i = 0; i < 40 && obsKQ.size() < 4; i++) applyStimulus();
        checkOutput("tie_grant_count", obsKQ.size() >= 4, 1);
        for (int i = 0; i < 4 && i < obsKQ.size(); i++) begin
            checkOutput("tie_grant_order", obsAddrQ[i], tieAddr[i % 2]);
            if (i > 0) checkOutput("tie_grant_spacing", obsKQ[i] - obsKQ[i-1], curWait + 3);
        end
        reqV = 2'b00;
        for (int i = 0; i < 6; i++) applyStimulus();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            randomDrive();
            applyStimulus();
        end
        reqV = 2'b00;
        for (int i = 0; i < 6; i++) applyStimulus();

        $display("[TB] reset during a write access");
        reqV[0] = 1'b1; wrV[0] = 1'b1; addrV[0] = 16'h0300; dataV[0] = 8'h77;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            applyStimulus();
            if (busy) done = 1'b1;
        end
        checkOutput("mid_access_reached", done, 1);
        checkOutput("mid_access_enable_low", oEnX, 0);
        reqV = 2'b00;
        rst  = 1'b1;
        applyStimulus();
        rst  = 1'b0;
        checkOutput("rst_enable_x", oEnX, 1);
        checkOutput("rst_write_x", oWrX, 1);
        checkOutput("rst_no_ack", {oAck1, oAck0}, 0);
        obsAddrQ.delete();
        obsKQ.delete();
        reqV = 2'b11; wrV = 2'b00;
        addrV[0] = 16'h0400; addrV[1] = 16'h0500;
        applyStimulus();
        checkOutput("post_rst_first_grant_seen", obsKQ.size(), 1);
        if (obsKQ.size() > 0) checkOutput("post_rst_tie_winner", obsAddrQ[0], addrV[0]);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            applyStimulus();
            if (oAck0) reqV[0] = 1'b0;
            if (oAck1) reqV[1] = 1'b0;
            if (reqV == 2'b00) done = 1'b1;
        end
        checkOutput("post_rst_drain", done, 1);
        for (int i = 0; i < 4; i++) applyStimulus();

        $display("[TB] address sweep with wrap");
        for (int j = 0; j < 512; j++) begin
            a = 16'(16'hFF00 + j);
            doTxn(1, 1'b1, a, a[7:0]);
        end
        for (int j = 0; j < 512; j++) begin
            a = 16'(16'hFF00 + j);
            doTxn(0, 1'b0, a, 8'h00);
            checkOutput("sweep_readback", oData0, a[7:0]);
        end
        for (int i = 0; i < 4; i++) applyStimulus();

        $display("[TB] WAIT=3 read of top address");
        sel     = 1'b1;
        curWait = 3;
        doReset();
        refMem[16'hFFFF] = 8'hC3;
        lowCnt = 0;
        doTxn(0, 1'b0, 16'hFFFF, 8'h00);
        checkOutput("w3_enable_low_cycles", lowCnt, 4);
        checkOutput("w3_latency", ackObsK - grantObsK, 4);
        checkOutput("w3_data0", oData0, 8'hC3);
        for (int i = 0; i < 4; i++) applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
